dly_load_sequencer: RTL and testbench

- Parametrised delay-programming engine for a multi-lane DDR3 PHY.
- Holds a shadow table of IDELAY/ODELAY values for NUM_LANES byte lanes.
- On an apply request, streams the table entries to the lanes over the existing dly_data/dly_addr/ld_delay/set bus, then issues one common set pulse.
- Adds per-entry dirty tracking, so only changed delays are reloaded unless a full reload is requested. Sits between the control/command interface and the byte lanes, all on clk_div.

---
 rtl/dly_load_sequencer_pkg.sv | 37 +++
 rtl/dly_load_sequencer_if.sv | 30 +++
 rtl/dly_slot_iter.sv | 40 ++++
 rtl/dly_load_sequencer.sv | 111 +++++++++++
 tb/tb_dly_load_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/dly_load_sequencer_pkg.sv
// Shared types and slot-map helpers for the PHY delay-load sequencer.
// Slot addresses follow the byte-lane delay map: ODELAY low, IDELAY at 16+.
package dly_load_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_SET
    } state_t;

    localparam logic [4:0] IDLY_BASE = 5'd16;

    function automatic logic [4:0] odly_dqs(int d);
        return 5'(d);
    endfunction

    function automatic logic [4:0] odly_dm(int d);
        return 5'(d + 1);
    endfunction

    function automatic logic [4:0] idly_dqs(int d);
        return 5'(32'(IDLY_BASE) + d);
    endfunction

    function automatic int slot_count(int d);
        return 2 * d + 3;
    endfunction

    function automatic logic slot_valid(logic [4:0] sel, int d);
        if (sel[4])
            return 32'(sel[3:0]) <= 32'(idly_dqs(d) - IDLY_BASE);
        else
            return 32'(sel[3:0]) <= 32'(odly_dm(d));
    endfunction

endpackage

// File: rtl/dly_load_sequencer_if.sv
// Control-side write/apply port and the shared delay bus toward the lanes.
// The sequencer is the slave; the controller and byte lanes sit on master.
interface dly_load_sequencer_if #(
    parameter int NUM_LANES = 2,
    parameter int DLY_WIDTH = 8,
    parameter int LANE_BITS = 3
);
    logic                   wr_en;
    logic [LANE_BITS+4:0]   wr_addr;
    logic [DLY_WIDTH-1:0]   wr_data;
    logic                   wr_rej;
    logic                   start;
    logic                   apply_all;
    logic                   busy;
    logic                   done;
    logic [DLY_WIDTH-1:0]   dly_data;
    logic [4:0]             dly_addr;
    logic [NUM_LANES-1:0]   ld_delay;
    logic [NUM_LANES-1:0]   set;

    modport master (
        output wr_en, wr_addr, wr_data, start, apply_all,
        input  wr_rej, busy, done, dly_data, dly_addr, ld_delay, set
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, apply_all,
        output wr_rej, busy, done, dly_data, dly_addr, ld_delay, set
    );
endinterface

// File: rtl/dly_slot_iter.sv
// Walks every valid lane/slot pair in load order, one per step.
// Wraps to lane 0 slot 0 after the last slot so it is ready for the next sweep.
module dly_slot_iter
    import dly_load_sequencer_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int DQ_PER_LANE = 8,
    parameter int LANE_BITS   = 3
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 step,
    output logic [LANE_BITS-1:0] lane,
    output logic [4:0]           sel,
    output logic                 last
);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);

    assign last = (lane == LAST_LANE) && (sel == idly_dqs(DQ_PER_LANE));

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            lane <= '0;
            sel  <= '0;
        end else if (step) begin
            if (last) begin
                lane <= '0;
                sel  <= '0;
            end else if (sel == odly_dm(DQ_PER_LANE)) begin
                sel <= IDLY_BASE;
            end else if (sel == idly_dqs(DQ_PER_LANE)) begin
                lane <= lane + LANE_BITS'(1);
                sel  <= '0;
            end else begin
                sel <= sel + 5'd1;
            end
        end
    end

endmodule

// File: rtl/dly_load_sequencer.sv
// Shadow IDELAY/ODELAY table with dirty tracking; streams entries to the
// byte lanes on request and finishes each sweep with a common set pulse.
module dly_load_sequencer
    import dly_load_sequencer_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int DQ_PER_LANE = 8,
    parameter int DLY_WIDTH   = 8,
    parameter int LANE_BITS   = 3
) (
    input  logic                 clk_div,
    input  logic                 rst,
    dly_load_sequencer_if.slave  bus
);
    localparam int ENTRIES = NUM_LANES * 32;
    localparam int IDX_W   = $clog2(ENTRIES);

    state_t               state;
    logic                 all_q;
    logic [DLY_WIDTH-1:0] tbl_q   [ENTRIES];
    logic                 dirty_q [ENTRIES];

    logic [LANE_BITS-1:0] wr_lane;
    logic [4:0]           wr_sel;
    logic                 wr_ok;
    logic [IDX_W-1:0]     wr_idx;

    logic [LANE_BITS-1:0] it_lane;
    logic [4:0]           it_sel;
    logic                 it_last;
    logic [IDX_W-1:0]     vis_idx;

    assign {wr_lane, wr_sel} = bus.wr_addr;
    assign wr_idx  = IDX_W'({wr_lane, wr_sel});
    assign vis_idx = IDX_W'({it_lane, it_sel});

    assign wr_ok = bus.wr_en && (state == S_IDLE)
                && ({1'b0, wr_lane} < (LANE_BITS+1)'(NUM_LANES))
                && slot_valid(wr_sel, DQ_PER_LANE);

    dly_slot_iter #(
        .NUM_LANES   (NUM_LANES),
        .DQ_PER_LANE (DQ_PER_LANE),
        .LANE_BITS   (LANE_BITS)
    ) u_iter (
        .clk_div (clk_div),
        .rst     (rst),
        .step    (state == S_SCAN),
        .lane    (it_lane),
        .sel     (it_sel),
        .last    (it_last)
    );

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            all_q        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.wr_rej   <= 1'b0;
            bus.ld_delay <= '0;
            bus.set      <= '0;
            bus.dly_data <= '0;
            bus.dly_addr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i]   <= '0;
                dirty_q[i] <= 1'b1;
            end
        end else begin
            bus.wr_rej   <= bus.wr_en && !wr_ok;
            bus.ld_delay <= '0;
            bus.set      <= '0;
            bus.done     <= 1'b0;
            if (wr_ok) begin
                tbl_q[wr_idx]   <= bus.wr_data;
                dirty_q[wr_idx] <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        all_q    <= bus.apply_all;
                        bus.busy <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // data/addr only move on a real load so lanes see stable values
                    if (dirty_q[vis_idx] || all_q) begin
                        bus.ld_delay <= NUM_LANES'(1) << it_lane;
                        bus.dly_data <= tbl_q[vis_idx];
                        bus.dly_addr <= it_sel;
                    end
                    dirty_q[vis_idx] <= 1'b0;
                    if (it_last)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    bus.set  <= '1;
                    bus.done <= 1'b1;
                    state    <= S_SET;
                end
                S_SET: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dly_load_sequencer.sv
// Randomised bench for dly_load_sequencer against a table-level model.
// The model tracks values and dirty flags per lane/slot and predicts loads.
module tb_dly_load_sequencer;
    localparam int NL = 2;
    localparam int D  = 8;
    localparam int DW = 8;
    localparam int LB = 3;
    localparam int S  = 2 * D + 3;

    logic clk_div = 1'b0;
    logic rst     = 1'b1;

    dly_load_sequencer_if #(
        .NUM_LANES (NL),
        .DLY_WIDTH (DW),
        .LANE_BITS (LB)
    ) bus ();

    dly_load_sequencer #(
        .NUM_LANES   (NL),
        .DQ_PER_LANE (D),
        .DLY_WIDTH   (DW),
        .LANE_BITS   (LB)
    ) dut (
        .clk_div (clk_div),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk_div = ~clk_div;

    int tests = 0;
    int fails = 0;
    int shadow [NL][32];
    bit dirty  [NL][32];

    task automatic check(string tag, int got, int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    function automatic bit valid_slot(int s);
        return (s <= D + 1) || (s >= 16 && s <= 16 + D);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++)
            for (int s = 0; s < 32; s++) begin
                shadow[l][s] = 0;
                dirty[l][s]  = 1'b1;
            end
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_rej"},  int'(bus.wr_rej), 0);
        check({tag, "_ld"},   int'(bus.ld_delay), 0);
        check({tag, "_set"},  int'(bus.set), 0);
        check({tag, "_data"}, int'(bus.dly_data), 0);
        check({tag, "_addr"}, int'(bus.dly_addr), 0);
    endtask

    task automatic do_write(int lane, int sel, int data);
        bit ok;
        bus.wr_en   = 1'b1;
        bus.wr_addr = {LB'(lane), 5'(sel)};
        bus.wr_data = DW'(data);
        step();
        bus.wr_en = 1'b0;
        ok = (lane < NL) && valid_slot(sel);
        check("wr_rej", int'(bus.wr_rej), int'(!ok));
        if (ok) begin
            shadow[lane][sel] = data;
            dirty[lane][sel]  = 1'b1;
        end
    endtask

    task automatic sweep(bit all, bit wr, int wl, int ws, int wd, bit busy_wr);
        int exp_q[$];
        int got_q[$];
        int nbusy   = 0;
        int set_at  = -1;
        int done_at = -1;
        int set_val = 0;
        int viol    = 0;
        int lane;
        bus.start     = 1'b1;
        bus.apply_all = all;
        if (wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = {LB'(wl), 5'(ws)};
            bus.wr_data = DW'(wd);
        end
        step();
        bus.start     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.apply_all = ~all;
        if (wr) begin
            check("wr_with_start_rej", int'(bus.wr_rej), 0);
            shadow[wl][ws] = wd;
            dirty[wl][ws]  = 1'b1;
        end
        for (int l = 0; l < NL; l++)
            for (int s = 0; s < 32; s++)
                if (valid_slot(s)) begin
                    if (all || dirty[l][s])
                        exp_q.push_back((l << 16) | (s << 8) | shadow[l][s]);
                    dirty[l][s] = 1'b0;
                end
        while (bus.busy && nbusy < 200) begin
            if (bus.ld_delay != 0) begin
                lane = 0;
                for (int i = 0; i < NL; i++)
                    if (bus.ld_delay[i]) lane = i;
                got_q.push_back((lane << 16) | (int'(bus.dly_addr) << 8)
                                | int'(bus.dly_data));
                if ($countones(bus.ld_delay) > 1) viol++;
                if (bus.set != 0) viol++;
            end
            if (bus.set != 0) begin
                set_at  = nbusy;
                set_val = int'(bus.set);
            end
            if (bus.done) done_at = nbusy;
            if (busy_wr && nbusy == 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = {LB'(0), 5'(0)};
                bus.wr_data = 8'hFF;
                bus.start   = 1'b1;
            end
            step();
            if (busy_wr && nbusy == 5) begin
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
                check("wr_busy_rej", int'(bus.wr_rej), 1);
            end
            nbusy++;
        end
        check("busy_len", nbusy, NL * S + 2);
        check("set_pos", set_at, nbusy - 1);
        check("done_pos", done_at, nbusy - 1);
        check("set_val", set_val, (1 << NL) - 1);
        check("strobe_overlap", viol, 0);
        check("post_done", int'(bus.done), 0);
        check("ld_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("ld_entry", got_q[i], exp_q[i]);
    endtask

    initial begin
        int nw;
        int sl;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.apply_all = 1'b0;
        model_reset();
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
        do_write(1, 17, 'h5A);
        sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
        sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);

        do_write(2, 3, 'h33);
        do_write(0, 10, 'h44);
        do_write(1, 25, 'h55);
        sweep(1'b0, 1'b0, 0, 0, 0, 1'b1);
        sweep(1'b1, 1'b0, 0, 0, 0, 1'b0);

        sweep(1'b0, 1'b1, 0, 3, 'h21, 1'b0);

        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(0, 6);
            for (int k = 0; k < nw; k++)
                do_write($urandom_range(0, 2), $urandom_range(0, 31),
                         $urandom_range(1, 255));
            sl = $urandom_range(0, 31);
            while (!valid_slot(sl)) sl = $urandom_range(0, 31);
            sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, NL - 1), sl, $urandom_range(1, 255), 1'b0);
        end

        do_write(0, 0, 'hA5);
        bus.start     = 1'b1;
        bus.apply_all = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #2;
        check_idle_outputs("midrst");
        step();
        rst = 1'b0;
        model_reset();
        step();
        sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
